vscpu_mem_responder: RTL and testbench

VSCPU_MEM_RESPONDER -- requirements
Module: vscpu_mem_responder

---
 rtl/vscpu_mem_responder_if.sv | 29 ++
 rtl/vscpu_mem_responder.sv | 100 ++++++++++
 tb/tb_vscpu_mem_responder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/vscpu_mem_responder_if.sv
// Bus bundle between the memory responder, the CPU port and the program loader.
interface vscpu_mem_responder_if #(
  parameter int unsigned SIZE = 14
);
  // CPU port
  logic            wrEn;
  logic [SIZE-1:0] addr_toRAM;
  logic [31:0]     data_toRAM;
  logic [31:0]     data_fromRAM;
  // Loader stream
  logic            ld_valid;
  logic [31:0]     ld_data;
  logic            ld_last;
  logic            ld_ready;
  // Status
  logic            cpu_rst;
  logic            loaded;
  logic [SIZE:0]   ld_count;

  modport slave (
    input  wrEn, addr_toRAM, data_toRAM, ld_valid, ld_data, ld_last,
    output data_fromRAM, ld_ready, cpu_rst, loaded, ld_count
  );

  modport master (
    output wrEn, addr_toRAM, data_toRAM, ld_valid, ld_data, ld_last,
    input  data_fromRAM, ld_ready, cpu_rst, loaded, ld_count
  );
endinterface

// File: rtl/vscpu_mem_responder.sv
// Word memory for VerySimpleCPU: filled by a streaming loader while the CPU is
// held in reset, then serves CPU reads/writes with one-cycle registered reads.
module vscpu_mem_responder #(
  parameter int unsigned SIZE = 14
) (
  input logic                  clk,
  input logic                  rst,
  vscpu_mem_responder_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** SIZE;
  localparam logic [SIZE:0] CountMax = (SIZE + 1)'(DEPTH);

  typedef enum logic [0:0] {StLoad, StRun} state_e;

  state_e          state_q, state_d;
  logic [SIZE-1:0] load_ptr_q, load_ptr_d;
  logic [SIZE:0]   ld_count_q, ld_count_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0]     mem [DEPTH];

  logic            ld_xfer;
  logic            cpu_we;
  logic            mem_we;
  logic [SIZE-1:0] mem_waddr;
  logic [31:0]     mem_wdata;
  logic            ready;
  logic            hold_cpu;
  logic            run;

  // Next-state, loader bookkeeping, read data and status outputs
  always_comb begin
    state_d    = state_q;
    load_ptr_d = load_ptr_q;
    ld_count_d = ld_count_q;
    rdata_d    = '0;
    ld_xfer    = 1'b0;
    cpu_we     = 1'b0;
    ready      = 1'b0;
    hold_cpu   = 1'b0;
    run        = 1'b0;
    unique case (state_q)
      StLoad: begin
        ready    = 1'b1;
        hold_cpu = 1'b1;
        ld_xfer  = bus.ld_valid;
        if (ld_xfer) begin
          load_ptr_d = load_ptr_q + 1'b1;
          if (ld_count_q != CountMax) begin
            ld_count_d = ld_count_q + 1'b1;
          end
          // Last marked word, or the word at the top address, ends the load
          if (bus.ld_last || (load_ptr_q == '1)) begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        run    = 1'b1;
        cpu_we = bus.wrEn;
        // Write-first: a write bypasses the array onto the read register
        rdata_d = bus.wrEn ? bus.data_toRAM : mem[bus.addr_toRAM];
      end
    endcase
  end

  // Control state; asynchronously returned to the load phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StLoad;
      load_ptr_q <= '0;
      ld_count_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      load_ptr_q <= load_ptr_d;
      ld_count_q <= ld_count_d;
      rdata_q    <= rdata_d;
    end
  end

  // Single write port shared by loader and CPU; gated by rst so no write
  // lands while reset is held
  assign mem_we    = (ld_xfer | cpu_we) & rst;
  assign mem_waddr = run ? bus.addr_toRAM : load_ptr_q;
  assign mem_wdata = run ? bus.data_toRAM : bus.ld_data;

  // Memory array; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.data_fromRAM = rdata_q;
  assign bus.ld_ready     = ready;
  assign bus.cpu_rst      = hold_cpu;
  assign bus.loaded       = run;
  assign bus.ld_count     = ld_count_q;
endmodule

// File: tb/tb_vscpu_mem_responder.sv
// Self-checking bench for vscpu_mem_responder (SIZE=14 and SIZE=4 instances).
module tb_vscpu_mem_responder;
  logic clk = 1'b0;
  logic rst;
  logic rst4;

  always #5 clk = ~clk;

  vscpu_mem_responder_if #(.SIZE(14)) bus ();
  vscpu_mem_responder_if #(.SIZE(4))  bus4 ();

  vscpu_mem_responder #(.SIZE(14)) dut (.clk(clk), .rst(rst), .bus(bus));
  vscpu_mem_responder #(.SIZE(4))  dut4 (.clk(clk), .rst(rst4), .bus(bus4));

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } run_vec_t;

  run_vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Loader word on the big instance; called and returns at a negedge
  task automatic ld_word(input logic v, input logic [31:0] d, input logic last);
    bus.ld_valid = v;
    bus.ld_data  = d;
    bus.ld_last  = last;
    @(posedge clk);
    @(negedge clk);
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic ld_word4(input logic v, input logic [31:0] d, input logic last);
    bus4.ld_valid = v;
    bus4.ld_data  = d;
    bus4.ld_last  = last;
    @(posedge clk);
    @(negedge clk);
    bus4.ld_valid = 1'b0;
    bus4.ld_last  = 1'b0;
  endtask

  // CPU cycle: expected read data goes to the scoreboard at drive time and is
  // popped when the registered read appears one cycle later
  task automatic cpu_op(input logic wr, input logic [13:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input string name, output logic [31:0] got);
    logic [31:0] e;
    bus.wrEn       = wr;
    bus.addr_toRAM = a;
    bus.data_toRAM = d;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    bus.wrEn = 1'b0;
    got = bus.data_fromRAM;
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(name, got, e);
    end
  endtask

  task automatic cpu_op4(input logic [3:0] a, input logic [31:0] exp, input string name);
    bus4.wrEn       = 1'b0;
    bus4.addr_toRAM = a;
    bus4.data_toRAM = '0;
    @(posedge clk);
    @(negedge clk);
    check(name, bus4.data_fromRAM, exp);
  endtask

  task automatic check_status(input string name, input logic rdy, input logic crst,
                              input logic ld, input logic [31:0] cnt);
    check({name, "_ld_ready"}, 32'(bus.ld_ready), 32'(rdy));
    check({name, "_cpu_rst"}, 32'(bus.cpu_rst), 32'(crst));
    check({name, "_loaded"}, 32'(bus.loaded), 32'(ld));
    check({name, "_ld_count"}, 32'(bus.ld_count), cnt);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] a_val;
    logic [31:0] b_val;

    vecs[0]  = '{1'b0, 14'h0001, 32'h0,        32'h0000_0022};
    vecs[1]  = '{1'b0, 14'h0000, 32'h0,        32'h0000_0011};
    vecs[2]  = '{1'b0, 14'h0002, 32'h0,        32'h0000_0033};
    vecs[3]  = '{1'b1, 14'h0005, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 14'h0005, 32'h0,        32'hDEADBEEF};
    vecs[5]  = '{1'b1, 14'h0007, 32'h0000_1234, 32'h0000_1234};
    vecs[6]  = '{1'b0, 14'h0007, 32'h0,        32'h0000_1234};
    vecs[7]  = '{1'b1, 14'h0000, 32'h0000_CAFE, 32'h0000_CAFE};
    vecs[8]  = '{1'b0, 14'h0000, 32'h0,        32'h0000_CAFE};
    vecs[9]  = '{1'b0, 14'h0001, 32'h0,        32'h0000_0022};
    vecs[10] = '{1'b1, 14'h3FFF, 32'h0000_55AA, 32'h0000_55AA};
    vecs[11] = '{1'b0, 14'h3FFF, 32'h0,        32'h0000_55AA};
    vecs[12] = '{1'b1, 14'h0010, 32'h0000_1010, 32'h0000_1010};

    rst  = 1'b0;
    rst4 = 1'b0;
    bus.wrEn = 1'b0;  bus.addr_toRAM = '0;  bus.data_toRAM = '0;
    bus.ld_valid = 1'b0;  bus.ld_data = '0;  bus.ld_last = 1'b0;
    bus4.wrEn = 1'b0; bus4.addr_toRAM = '0; bus4.data_toRAM = '0;
    bus4.ld_valid = 1'b0; bus4.ld_data = '0; bus4.ld_last = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check_status("reset", 1'b1, 1'b1, 1'b0, 32'd0);
    check("reset_rdata", bus.data_fromRAM, 32'd0);
    rst = 1'b1;

    // Three-word load, last marked on the third
    ld_word(1'b1, 32'h11, 1'b0);
    check_status("load1", 1'b1, 1'b1, 1'b0, 32'd1);
    ld_word(1'b1, 32'h22, 1'b0);
    ld_word(1'b1, 32'h33, 1'b1);
    check_status("load3_run", 1'b0, 1'b0, 1'b1, 32'd3);

    // RUN-mode vector table
    for (int i = 0; i < 13; i++) begin
      cpu_op(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp, $sformatf("vec%0d", i), got);
    end

    // Loader ignored in RUN
    ld_word(1'b1, 32'h77, 1'b1);
    check("run_ld_ignored_count", 32'(bus.ld_count), 32'd3);
    cpu_op(1'b0, 14'h0000, 32'h0, 32'h0000_CAFE, "run_ld_ignored_mem0", got);

    // Reload with valid gaps; CPU port driven during load must be ignored
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rerst_count", 32'(bus.ld_count), 32'd0);
    bus.wrEn = 1'b1; bus.addr_toRAM = 14'h0010; bus.data_toRAM = 32'h0000_0BAD;
    ld_word(1'b1, 32'hA1, 1'b0);
    check("load_cpu_rdata_zero", bus.data_fromRAM, 32'd0);
    ld_word(1'b0, 32'hEE, 1'b1);
    ld_word(1'b0, 32'hEE, 1'b1);
    check_status("gap", 1'b1, 1'b1, 1'b0, 32'd1);
    ld_word(1'b1, 32'hA2, 1'b1);
    bus.wrEn = 1'b0;
    check_status("gap_run", 1'b0, 1'b0, 1'b1, 32'd2);
    cpu_op(1'b0, 14'h0000, 32'h0, 32'h0000_00A1, "gap_mem0", got);
    cpu_op(1'b0, 14'h0001, 32'h0, 32'h0000_00A2, "gap_mem1", got);
    cpu_op(1'b0, 14'h0002, 32'h0, 32'h0000_0033, "gap_mem2_kept", got);
    cpu_op(1'b0, 14'h0010, 32'h0, 32'h0000_1010, "gap_cpu_wr_ignored", got);

    // Asynchronous reset between edges mid-load
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ld_word(1'b1, 32'h55, 1'b0);
    ld_word(1'b1, 32'h66, 1'b0);
    check("midload_count", 32'(bus.ld_count), 32'd2);
    #2 rst = 1'b0;
    #1 check_status("async_load", 1'b1, 1'b1, 1'b0, 32'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    ld_word(1'b1, 32'hAA, 1'b1);
    check("reload_loaded", 32'(bus.loaded), 32'd1);
    cpu_op(1'b0, 14'h0000, 32'h0, 32'h0000_00AA, "reload_mem0", got);
    cpu_op(1'b0, 14'h0001, 32'h0, 32'h0000_0066, "reload_mem1_kept", got);

    // Asynchronous reset mid-run clears the read register immediately
    #2 rst = 1'b0;
    #1 check("async_run_rdata", bus.data_fromRAM, 32'd0);
    check("async_run_loaded", 32'(bus.loaded), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Tiny ADD program image: operands at 2 and 3, result to 4
    ld_word(1'b1, 32'h0, 1'b0);
    ld_word(1'b1, 32'h0, 1'b0);
    ld_word(1'b1, 32'd7, 1'b0);
    ld_word(1'b1, 32'd35, 1'b1);
    cpu_op(1'b0, 14'h0002, 32'h0, 32'd7, "add_rd_a", a_val);
    cpu_op(1'b0, 14'h0003, 32'h0, 32'd35, "add_rd_b", b_val);
    cpu_op(1'b1, 14'h0004, a_val + b_val, a_val + b_val, "add_wr", got);
    cpu_op(1'b0, 14'h0004, 32'h0, 32'd42, "add_result", got);

    // SIZE=4: stream fills all 16 words and wraps into RUN without ld_last
    rst4 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ld_word4(1'b1, 32'h100 + 32'(i), 1'b0);
      if (i == 14) begin
        check("s4_15_loaded", 32'(bus4.loaded), 32'd0);
        check("s4_15_count", 32'(bus4.ld_count), 32'd15);
      end
    end
    check("s4_16_loaded", 32'(bus4.loaded), 32'd1);
    check("s4_16_ready", 32'(bus4.ld_ready), 32'd0);
    check("s4_16_count", 32'(bus4.ld_count), 32'd16);
    ld_word4(1'b1, 32'hFFFF_FFFF, 1'b0);
    check("s4_17_count", 32'(bus4.ld_count), 32'd16);
    cpu_op4(4'h0, 32'h100, "s4_mem0");
    cpu_op4(4'hF, 32'h10F, "s4_mem15");

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
